// File: rtl/sreg_lane_buffer.sv
// Multi-lane word-collecting shift buffer: DEPTH beats of LANES words form one block.
// A full block is held under backpressure, and the consuming cycle can refill it with no gap.
module sreg_lane_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LANES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*WIDTH-1:0]         din,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*DEPTH*WIDTH-1:0]   res,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = DEPTH * WIDTH;

    localparam logic FILL = 1'b0;
    localparam logic FULL = 1'b1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          state;
    logic [LW-1:0] lane [LANES];
    logic          accept;
    logic          consume;

    assign out_valid = (state == FULL);
    // While full, a slot frees up only in the cycle the consumer takes the block.
    assign in_ready  = (state == FILL) ? 1'b1 : out_ready;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        res = '0;
        for (int k = 0; k < LANES; k++) begin
            res[(LANES-k)*LW-1 -: LW] = lane[k];
        end
    end

    // NOTE: state is updated with non-blocking assignments, so every branch sees pre-edge values.
    // NOTE: the lane registers are small flops, not a RAM, so they can share the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            count <= '0;
            for (int k = 0; k < LANES; k++) begin
                lane[k] <= '0;
            end
        end else if (clr) begin
            state <= FILL;
            count <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < LANES; k++) begin
                    lane[k] <= {lane[k][LW-WIDTH-1:0], din[(LANES-k)*WIDTH-1 -: WIDTH]};
                end
            end
            case (state)
                FILL: begin
                    if (accept) begin
                        if (count == CNT_LAST) begin
                            state <= FULL;
                            count <= CNT_FULL;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end
                end
                FULL: begin
                    // An accept here is only possible when the block is consumed in the same cycle.
                    if (consume) begin
                        state <= FILL;
                        count <= accept ? CNT_ONE : '0;
                    end
                end
                default: begin
                    state <= FILL;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
